// File: rtl/ifm_pkg.sv
// Shared types and sizing for the IFM pack writer: FSM state encoding and lane geometry.
package ifm_pkg;

   localparam int unsigned IFM_IN_W   = 32;
   localparam int unsigned IFM_OUT_W  = 128;
   localparam int unsigned IFM_ADDR_W = 32;
   localparam int unsigned LANES      = IFM_OUT_W / IFM_IN_W;
   localparam int unsigned LANE_W     = $clog2(LANES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_LAST = 2'd2,
      S_DONE = 2'd3
   } ifm_pack_state_t;

endpackage : ifm_pkg

// File: rtl/ifm_pack_writer_lane_packer.sv
// Lane accumulator: inserts input beats into successive lanes of a wide word and
// presents the merged word (including the beat being inserted) combinationally.
module lane_packer
   import ifm_pkg::*;
#(
   parameter int unsigned IN_W = IFM_IN_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_clear,
   input  logic                    i_insert,
   input  logic                    i_pad_flush,
   input  logic [IN_W-1:0]         i_data,
   output logic [LANE_W-1:0]       o_lane,
   output logic [LANES*IN_W-1:0]   o_word_c
);

   logic [LANES*IN_W-1:0] r_word;
   logic [LANE_W-1:0]     r_lane;
   logic                  w_full;

   assign w_full = (r_lane == LANE_W'(LANES - 1));
   assign o_lane = r_lane;

   // Merged view: stored lanes below, new beat at the current lane, zero pad above on flush.
   always_comb begin
      o_word_c = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (l == 32'(r_lane))
            o_word_c[l*IN_W +: IN_W] = i_data;
         else if ((l > 32'(r_lane)) && i_pad_flush)
            o_word_c[l*IN_W +: IN_W] = '0;
         else
            o_word_c[l*IN_W +: IN_W] = r_word[l*IN_W +: IN_W];
      end
   end

   // Lanes are wiped whenever a word leaves so padding never carries stale beats.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_word <= '0;
         r_lane <= '0;
      end else if (i_insert) begin
         if (w_full || i_pad_flush) begin
            r_word <= '0;
            r_lane <= '0;
         end else begin
            r_word[32'(r_lane)*IN_W +: IN_W] <= i_data;
            r_lane                           <= r_lane + LANE_W'(1);
         end
      end
   end

endmodule : lane_packer

// File: rtl/ifm_pack_writer.sv
// Packs a 32-bit beat stream into 128-bit words and writes them to the IFM buffer
// at sequential addresses from a host-supplied base, pulsing done at the end.
module ifm_pack_writer
   import ifm_pkg::*;
#(
   parameter int unsigned IN_W   = IFM_IN_W,
   parameter int unsigned OUT_W  = IFM_OUT_W,
   parameter int unsigned ADDR_W = IFM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       num_beats,
   input  logic [IN_W-1:0]   s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              wr_rd_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [OUT_W-1:0]  wr_data,
   output logic              busy,
   output logic              done
);

   ifm_pack_state_t   r_state;
   logic [ADDR_W-1:0] r_base;
   logic [31:0]       r_beats_rem;
   logic [ADDR_W-1:0] r_word_idx;
   logic              r_s_ready;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [OUT_W-1:0]  r_wr_data;
   logic              r_busy;
   logic              r_done;

   logic              w_accept;
   logic              w_last_beat;
   logic              w_word_end;
   logic              w_start_go;
   logic [LANE_W-1:0] w_lane;
   logic [OUT_W-1:0]  w_word;

   assign w_accept    = r_s_ready && s_valid;
   assign w_last_beat = (r_beats_rem == 32'd1);
   assign w_word_end  = (w_lane == LANE_W'(LANES - 1));
   assign w_start_go  = (r_state == S_IDLE) && start && (num_beats != 32'd0);

   lane_packer #(.IN_W(IN_W)) u_lane_packer (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_start_go),
      .i_insert    (w_accept),
      .i_pad_flush (w_accept && w_last_beat),
      .i_data      (s_data),
      .o_lane      (w_lane),
      .o_word_c    (w_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_beats_rem <= '0;
         r_word_idx  <= '0;
         r_s_ready   <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (num_beats != 32'd0) begin
                     r_base      <= base_addr;
                     r_beats_rem <= num_beats;
                     r_word_idx  <= '0;
                     r_s_ready   <= 1'b1;
                     r_busy      <= 1'b1;
                     r_state     <= S_FILL;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_FILL: begin
               if (w_accept) begin
                  r_beats_rem <= r_beats_rem - 32'd1;
                  // A word leaves on a full lane set or on the final (possibly short) beat.
                  if (w_word_end || w_last_beat) begin
                     r_wr_en    <= 1'b1;
                     r_wr_addr  <= ADDR_W'(r_base + r_word_idx);
                     r_wr_data  <= w_word;
                     r_word_idx <= r_word_idx + ADDR_W'(1);
                  end
                  if (w_last_beat) begin
                     r_s_ready <= 1'b0;
                     r_state   <= S_LAST;
                  end
               end
            end
            S_LAST: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign s_ready  = r_s_ready;
   assign wr_rd_en = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule : ifm_pack_writer

// File: tb/tb_ifm_pack_writer.sv
// Directed bench for ifm_pack_writer: a table of transfers plus hand-written
// zero-length and reset-abort sequences, checked against hand-computed words.
module tb_ifm_pack_writer;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [31:0]  base_addr;
   logic [31:0]  num_beats;
   logic [31:0]  s_data;
   logic         s_valid;
   logic         s_ready;
   logic         wr_rd_en;
   logic [31:0]  wr_addr;
   logic [127:0] wr_data;
   logic         busy;
   logic         done;

   int checks   = 0;
   int failures = 0;

   logic [31:0]  q_addr[$];
   logic [127:0] q_data[$];

   typedef struct {
      logic [31:0]  base;
      int           n;
      logic [31:0]  mult;
      bit           gap;
      bit           stray;
      int           nw;
      logic [31:0]  a0;
      logic [127:0] d0;
      logic [31:0]  a1;
      logic [127:0] d1;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   ifm_pack_writer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .num_beats (num_beats),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .wr_rd_en  (wr_rd_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done)
   );

   // Write monitor: every strobed write is logged for end-of-transfer comparison.
   always @(negedge clk) begin
      if (wr_rd_en === 1'b1) begin
         q_addr.push_back(wr_addr);
         q_data.push_back(wr_data);
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_s_ready"},  128'(s_ready),  128'd0);
      chk({tag, "_wr_rd_en"}, 128'(wr_rd_en), 128'd0);
      chk({tag, "_wr_addr"},  128'(wr_addr),  128'd0);
      chk({tag, "_wr_data"},  wr_data,        128'd0);
      chk({tag, "_busy"},     128'(busy),     128'd0);
      chk({tag, "_done"},     128'(done),     128'd0);
   endtask

   task automatic run_xfer(input vec_t v);
      logic [31:0] last_a;
      q_addr.delete();
      q_data.delete();
      @(posedge clk); #1;
      start = 1'b1; base_addr = v.base; num_beats = 32'(v.n);
      @(posedge clk); #1;
      start = 1'b0; base_addr = '0; num_beats = '0;
      @(negedge clk);
      chk("busy_after_start",    128'(busy),    128'd1);
      chk("s_ready_after_start", 128'(s_ready), 128'd1);
      for (int i = 0; i < v.n; i++) begin
         if (v.gap && i > 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
         s_data  = v.mult * 32'(i + 1);
         s_valid = 1'b1;
         if (v.stray && i == 2) begin
            start = 1'b1; num_beats = 32'd3;
         end
         @(posedge clk); #1;
         start = 1'b0; num_beats = '0;
      end
      s_valid = 1'b0;
      s_data  = '0;
      last_a  = (v.nw > 1) ? v.a1 : v.a0;
      @(negedge clk);
      chk("final_write_strobe", 128'(wr_rd_en), 128'd1);
      chk("s_ready_in_last",    128'(s_ready),  128'd0);
      @(negedge clk);
      chk("done_latency",    128'(done),     128'd1);
      chk("busy_at_done",    128'(busy),     128'd0);
      chk("no_write_at_done", 128'(wr_rd_en), 128'd0);
      chk("addr_hold",       128'(wr_addr),  128'(last_a));
      @(negedge clk);
      chk("done_one_cycle", 128'(done), 128'd0);
      chk("write_count", 128'(q_addr.size()), 128'(v.nw));
      if (q_addr.size() >= 1) begin
         chk("addr0", 128'(q_addr[0]), 128'(v.a0));
         chk("data0", q_data[0], v.d0);
      end
      if (v.nw > 1 && q_addr.size() >= 2) begin
         chk("addr1", 128'(q_addr[1]), 128'(v.a1));
         chk("data1", q_data[1], v.d1);
      end
   endtask

   initial begin
      tbl[0] = '{32'h10, 8, 32'h11111111, 1'b0, 1'b0, 2,
                 32'h10, 128'h44444444_33333333_22222222_11111111,
                 32'h11, 128'h88888888_77777777_66666666_55555555};
      tbl[1] = '{32'h20, 5, 32'h1, 1'b0, 1'b0, 2,
                 32'h20, 128'h00000004_00000003_00000002_00000001,
                 32'h21, 128'h00000000_00000000_00000000_00000005};
      tbl[2] = '{32'h30, 4, 32'h01010101, 1'b1, 1'b0, 1,
                 32'h30, 128'h04040404_03030303_02020202_01010101,
                 32'h0, 128'h0};
      tbl[3] = '{32'hFFFFFFFF, 8, 32'h11111111, 1'b0, 1'b0, 2,
                 32'hFFFFFFFF, 128'h44444444_33333333_22222222_11111111,
                 32'h00000000, 128'h88888888_77777777_66666666_55555555};
      tbl[4] = '{32'h50, 6, 32'h10, 1'b0, 1'b1, 2,
                 32'h50, 128'h00000040_00000030_00000020_00000010,
                 32'h51, 128'h00000000_00000000_00000060_00000050};
      tbl[5] = '{32'h60, 1, 32'hDEADBEEF, 1'b0, 1'b0, 1,
                 32'h60, 128'h00000000_00000000_00000000_DEADBEEF,
                 32'h0, 128'h0};
      tbl[6] = '{32'h80, 3, 32'h0F0F0F0F, 1'b0, 1'b0, 1,
                 32'h80, 128'h00000000_2D2D2D2D_1E1E1E1E_0F0F0F0F,
                 32'h0, 128'h0};

      rst = 1'b1; start = 1'b0; base_addr = '0; num_beats = '0;
      s_data = '0; s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("reset");

      for (int k = 0; k < 6; k++) run_xfer(tbl[k]);

      // Zero-length transfer: done the cycle after start, nothing written.
      q_addr.delete();
      q_data.delete();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 32'h90; num_beats = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("zero_len_done", 128'(done), 128'd1);
      chk("zero_len_busy", 128'(busy), 128'd0);
      @(negedge clk);
      chk("zero_len_done_pulse", 128'(done), 128'd0);
      repeat (3) @(negedge clk);
      chk("zero_len_writes", 128'(q_addr.size()), 128'd0);

      // Reset after two of four beats: partial word discarded, then a clean transfer.
      q_addr.delete();
      q_data.delete();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 32'h70; num_beats = 32'd4;
      @(posedge clk); #1;
      start = 1'b0; num_beats = '0;
      for (int i = 0; i < 2; i++) begin
         s_data = 32'hAAAA0001 + 32'(i);
         s_valid = 1'b1;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("mid_reset");
      repeat (3) @(negedge clk);
      chk("mid_reset_writes", 128'(q_addr.size()), 128'd0);
      run_xfer(tbl[6]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_ifm_pack_writer
